// File: rtl/ddr4_cmd_sequencer.sv
// ddr4_cmd_sequencer
//   Turns one write/read burst request at a time into a DDR4 ACT/WR/RD/PRE
//   command sequence with programmable timing. Write bursts are driven on
//   dq_out/dqs; read bursts are captured from dq_in into rdata. An open-row
//   table per rank/bank supports closed-page (auto PRE) or open-page policy.
//
// Ports
//   ck_t, reset_n             clock (posedge) and async active-low reset
//   req_valid/req_ready       request handshake, ready only while idle
//   req_write, req_rank, req_bg, req_ba, req_row, req_col, req_wdata
//                             request fields, all sampled at accept
//   rdata, rdata_valid        captured read burst and its 1-cycle strobe
//   cs_n, act_n, A, bg, ba    command bus (one-cycle commands)
//   dq_out, dq_oe, dq_in      data bus and its output enable
//   dqs_t, dqs_c              write strobe pair
//   sync                      per-bank "row open in any rank" flags
module ddr4_cmd_sequencer #(
    parameter int RANKS        = 1,
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int ADDRWIDTH    = 17,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int CHIPS        = 16,
    parameter int BL           = 8,
    parameter int TRCD         = 15,
    parameter int TCL          = 10,
    parameter int TCWL         = 9,
    parameter int TWR          = 12,
    parameter int TRP          = 15,
    parameter int OPEN_PAGE    = 0,
    localparam int DQWIDTH     = DEVICE_WIDTH * CHIPS,
    localparam int BANKS       = 2 ** (BGWIDTH + BAWIDTH),
    localparam int RKW         = (RANKS > 1) ? $clog2(RANKS) : 1
) (
    input  logic                    ck_t,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [RKW-1:0]          req_rank,
    input  logic [BGWIDTH-1:0]      req_bg,
    input  logic [BAWIDTH-1:0]      req_ba,
    input  logic [ADDRWIDTH-1:0]    req_row,
    input  logic [COLWIDTH-1:0]     req_col,
    input  logic [DQWIDTH*BL-1:0]   req_wdata,
    output logic [DQWIDTH*BL-1:0]   rdata,
    output logic                    rdata_valid,
    output logic [RANKS-1:0]        cs_n,
    output logic                    act_n,
    output logic [ADDRWIDTH-1:0]    A,
    output logic [BGWIDTH-1:0]      bg,
    output logic [BAWIDTH-1:0]      ba,
    output logic [DQWIDTH-1:0]      dq_out,
    output logic                    dq_oe,
    input  logic [DQWIDTH-1:0]      dq_in,
    output logic [CHIPS-1:0]        dqs_t,
    output logic [CHIPS-1:0]        dqs_c,
    output logic [BANKS-1:0]        sync
);

    localparam int BKW  = BGWIDTH + BAWIDTH;
    localparam int RK_N = 2 ** RKW;
    localparam int M1   = (TRCD > TCL) ? TRCD : TCL;
    localparam int M2   = (TCWL > TWR) ? TCWL : TWR;
    localparam int M3   = (M1 > M2) ? M1 : M2;
    localparam int MAXT = (M3 > TRP) ? M3 : TRP;
    localparam int CW   = $clog2(MAXT + BL + 1);

    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_PRE = 3'b010;

    typedef enum logic [3:0] {
        S_IDLE, S_PRE_M, S_WAIT_RPM, S_ACT, S_WAIT_RCD,
        S_CMD, S_DATA, S_WAIT_WR, S_PRE, S_WAIT_RP
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic                    lat_write;
    logic [RKW-1:0]          lat_rank;
    logic [BKW-1:0]          lat_bank;
    logic [ADDRWIDTH-1:0]    lat_row;
    logic [COLWIDTH-1:0]     lat_col;
    logic [DQWIDTH*BL-1:0]   wdata_q;

    // Table sized to the full rank index range so indexing never runs past it.
    logic [BANKS-1:0]        open_vld [RK_N];
    logic [ADDRWIDTH-1:0]    open_row [RK_N][BANKS];

    logic [BKW-1:0]          req_bank;
    logic                    tbl_vld;
    logic                    tbl_match;
    logic [DQWIDTH-1:0]      beat_wr;

    function automatic logic [ADDRWIDTH-1:0] col_addr(input logic [2:0] c,
                                                      input logic [COLWIDTH-1:0] col);
        logic [ADDRWIDTH-1:0] a;
        a = '0;
        a[ADDRWIDTH-1 -: 3] = c;
        a[COLWIDTH-1:0] = col;
        return a;
    endfunction

    function automatic logic [RANKS-1:0] rank_sel(input logic [RKW-1:0] r);
        return ~(RANKS'(1) << r);
    endfunction

    assign req_bank  = {req_bg, req_ba};
    assign tbl_vld   = open_vld[req_rank][req_bank];
    assign tbl_match = (open_row[req_rank][req_bank] == req_row);

    // During a write the beat for the NEXT cycle is selected: cnt = BL..1
    // maps to beats 0..BL-1 because outputs are registered.
    always_comb begin
        beat_wr = '0;
        for (int k = 0; k < BL; k++)
            if (cnt == CW'(BL - k)) beat_wr = wdata_q[k*DQWIDTH +: DQWIDTH];
    end

    always_comb begin
        sync = '0;
        for (int r = 0; r < RANKS; r++) sync = sync | open_vld[r];
    end

    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            req_ready   <= 1'b0;
            lat_write   <= 1'b0;
            lat_rank    <= '0;
            lat_bank    <= '0;
            lat_row     <= '0;
            lat_col     <= '0;
            wdata_q     <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            cs_n        <= '1;
            act_n       <= 1'b1;
            A           <= '0;
            bg          <= '0;
            ba          <= '0;
            dq_out      <= '0;
            dq_oe       <= 1'b0;
            dqs_t       <= '0;
            dqs_c       <= '1;
            for (int r = 0; r < RK_N; r++) begin
                open_vld[r] <= '0;
                for (int b = 0; b < BANKS; b++) open_row[r][b] <= '0;
            end
        end else begin
            // Bus defaults: idle command bus, strobes parked, no data.
            cs_n        <= '1;
            act_n       <= 1'b1;
            A           <= '0;
            dq_out      <= '0;
            dq_oe       <= 1'b0;
            dqs_t       <= '0;
            dqs_c       <= '1;
            rdata_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        lat_write <= req_write;
                        lat_rank  <= req_rank;
                        lat_bank  <= req_bank;
                        lat_row   <= req_row;
                        lat_col   <= req_col;
                        wdata_q   <= req_wdata;
                        bg        <= req_bg;
                        ba        <= req_ba;
                        cs_n      <= rank_sel(req_rank);
                        if (OPEN_PAGE != 0 && tbl_vld && tbl_match) begin
                            A     <= col_addr(req_write ? C_WR : C_RD, req_col);
                            state <= S_CMD;
                        end else if (tbl_vld) begin
                            A     <= col_addr(C_PRE, req_col);
                            open_vld[req_rank][req_bank] <= 1'b0;
                            state <= S_PRE_M;
                        end else begin
                            act_n <= 1'b0;
                            A     <= req_row;
                            open_vld[req_rank][req_bank] <= 1'b1;
                            open_row[req_rank][req_bank] <= req_row;
                            state <= S_ACT;
                        end
                    end
                end
                S_PRE_M: begin
                    cnt   <= CW'(TRP - 1);
                    state <= S_WAIT_RPM;
                end
                S_WAIT_RPM: begin
                    if (cnt == '0) begin
                        cs_n  <= rank_sel(lat_rank);
                        act_n <= 1'b0;
                        A     <= lat_row;
                        open_vld[lat_rank][lat_bank] <= 1'b1;
                        open_row[lat_rank][lat_bank] <= lat_row;
                        state <= S_ACT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_ACT: begin
                    // ACT occupies one of the TRCD cycles itself.
                    if (TRCD <= 1) begin
                        cs_n  <= rank_sel(lat_rank);
                        A     <= col_addr(lat_write ? C_WR : C_RD, lat_col);
                        state <= S_CMD;
                    end else begin
                        cnt   <= CW'(TRCD - 2);
                        state <= S_WAIT_RCD;
                    end
                end
                S_WAIT_RCD: begin
                    if (cnt == '0) begin
                        cs_n  <= rank_sel(lat_rank);
                        A     <= col_addr(lat_write ? C_WR : C_RD, lat_col);
                        state <= S_CMD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_CMD: begin
                    // Latency wait and the BL beats share one countdown;
                    // the last BL counts (BL-1..0) are the beat cycles.
                    cnt   <= lat_write ? CW'(TCWL + BL - 1) : CW'(TCL + BL - 1);
                    state <= S_DATA;
                end
                S_DATA: begin
                    cnt <= cnt - 1'b1;
                    if (lat_write) begin
                        if (cnt != '0 && cnt <= CW'(BL)) begin
                            dq_oe  <= 1'b1;
                            dq_out <= beat_wr;
                            dqs_t  <= '1;
                            dqs_c  <= '0;
                        end
                        if (cnt == '0) begin
                            cnt   <= CW'(TWR - 1);
                            state <= S_WAIT_WR;
                        end
                    end else begin
                        for (int k = 0; k < BL; k++)
                            if (cnt == CW'(BL - 1 - k))
                                rdata[k*DQWIDTH +: DQWIDTH] <= dq_in;
                        if (cnt == '0) begin
                            rdata_valid <= 1'b1;
                            if (OPEN_PAGE == 0) begin
                                cs_n  <= rank_sel(lat_rank);
                                A     <= col_addr(C_PRE, lat_col);
                                open_vld[lat_rank][lat_bank] <= 1'b0;
                                state <= S_PRE;
                            end else begin
                                req_ready <= 1'b1;
                                state     <= S_IDLE;
                            end
                        end
                    end
                end
                S_WAIT_WR: begin
                    if (cnt == '0) begin
                        if (OPEN_PAGE == 0) begin
                            cs_n  <= rank_sel(lat_rank);
                            A     <= col_addr(C_PRE, lat_col);
                            open_vld[lat_rank][lat_bank] <= 1'b0;
                            state <= S_PRE;
                        end else begin
                            req_ready <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_PRE: begin
                    cnt   <= CW'(TRP - 1);
                    state <= S_WAIT_RP;
                end
                S_WAIT_RP: begin
                    if (cnt == '0) begin
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// Bench for ddr4_cmd_sequencer: a closed-page single-rank instance and an
// open-page dual-rank instance share the request/dq_in inputs. Each request
// is checked cycle by cycle against a schedule derived from the timing rules
// plus an open-row table and a burst memory kept in the bench.
module tb_ddr4_cmd_sequencer;

    localparam int TRCD = 15, TCL = 10, TCWL = 9, TWR = 12, TRP = 15, BL = 8;

    logic         ck_t = 1'b0;
    logic         reset_n;
    logic         v_cp, v_op;
    logic         req_write;
    logic [0:0]   req_rank;
    logic [1:0]   req_bg, req_ba;
    logic [16:0]  req_row;
    logic [9:0]   req_col;
    logic [511:0] req_wdata;
    logic [63:0]  dq_in;

    logic rdy_cp, rv_cp, act_cp, oe_cp, rdy_op, rv_op, act_op, oe_op;
    logic [511:0] rdata_cp, rdata_op;
    logic [0:0]   cs_cp;
    logic [1:0]   cs_op;
    logic [16:0]  a_cp, a_op;
    logic [1:0]   bg_cp, ba_cp, bg_op, ba_op;
    logic [63:0]  dq_cp, dq_op;
    logic [15:0]  dqst_cp, dqsc_cp, sync_cp, dqst_op, dqsc_op, sync_op;

    always #5 ck_t = ~ck_t;

    ddr4_cmd_sequencer #(.RANKS(1), .OPEN_PAGE(0), .TRCD(TRCD), .TCL(TCL), .TCWL(TCWL),
                         .TWR(TWR), .TRP(TRP), .BL(BL)) u_cp (
        .ck_t(ck_t), .reset_n(reset_n), .req_valid(v_cp), .req_ready(rdy_cp),
        .req_write(req_write), .req_rank(req_rank), .req_bg(req_bg), .req_ba(req_ba),
        .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
        .rdata(rdata_cp), .rdata_valid(rv_cp), .cs_n(cs_cp), .act_n(act_cp), .A(a_cp),
        .bg(bg_cp), .ba(ba_cp), .dq_out(dq_cp), .dq_oe(oe_cp), .dq_in(dq_in),
        .dqs_t(dqst_cp), .dqs_c(dqsc_cp), .sync(sync_cp));

    ddr4_cmd_sequencer #(.RANKS(2), .OPEN_PAGE(1), .TRCD(TRCD), .TCL(TCL), .TCWL(TCWL),
                         .TWR(TWR), .TRP(TRP), .BL(BL)) u_op (
        .ck_t(ck_t), .reset_n(reset_n), .req_valid(v_op), .req_ready(rdy_op),
        .req_write(req_write), .req_rank(req_rank), .req_bg(req_bg), .req_ba(req_ba),
        .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
        .rdata(rdata_op), .rdata_valid(rv_op), .cs_n(cs_op), .act_n(act_op), .A(a_op),
        .bg(bg_op), .ba(ba_op), .dq_out(dq_op), .dq_oe(oe_op), .dq_in(dq_in),
        .dqs_t(dqst_op), .dqs_c(dqsc_op), .sync(sync_op));

    // Observed view of whichever instance the current request targets.
    logic         sel;
    logic         o_rdy, o_rv, o_act, o_oe;
    logic [511:0] o_rdata;
    logic [1:0]   o_cs, o_bg, o_ba;
    logic [16:0]  o_a;
    logic [63:0]  o_dq;
    logic [15:0]  o_dqst, o_dqsc, o_sync;
    assign o_rdy   = sel ? rdy_op   : rdy_cp;
    assign o_rv    = sel ? rv_op    : rv_cp;
    assign o_act   = sel ? act_op   : act_cp;
    assign o_oe    = sel ? oe_op    : oe_cp;
    assign o_rdata = sel ? rdata_op : rdata_cp;
    assign o_cs    = sel ? cs_op    : {1'b1, cs_cp};
    assign o_bg    = sel ? bg_op    : bg_cp;
    assign o_ba    = sel ? ba_op    : ba_cp;
    assign o_a     = sel ? a_op     : a_cp;
    assign o_dq    = sel ? dq_op    : dq_cp;
    assign o_dqst  = sel ? dqst_op  : dqst_cp;
    assign o_dqsc  = sel ? dqsc_op  : dqsc_cp;
    assign o_sync  = sel ? sync_op  : sync_cp;

    int errors = 0;
    int checks = 0;

    // Reference state: open-row table [instance][rank][bank] and burst memory.
    bit           m_vld [2][2][16];
    logic [16:0]  m_row [2][2][16];
    logic [511:0] mem [bit [32:0]];

    function automatic logic [511:0] rand_burst();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [15:0] model_sync(input bit w);
        logic [15:0] s;
        s = '0;
        for (int r = 0; r < 2; r++)
            for (int b = 0; b < 16; b++)
                if (m_vld[w][r][b]) s[b] = 1'b1;
        return s;
    endfunction

    task automatic clear_model();
        for (int w = 0; w < 2; w++)
            for (int r = 0; r < 2; r++)
                for (int b = 0; b < 16; b++) m_vld[w][r][b] = 1'b0;
    endtask

    // Issue one request to instance 'which' (0 = closed page, 1 = open page)
    // and check every cycle until ready returns. Returns at the negedge of
    // the first ready cycle, or right after asserting reset at abort_at.
    task automatic do_req(input bit which, input bit wr, input bit rank, input int bank,
                          input logic [16:0] row, input logic [9:0] col, input bit hold,
                          input int abort_at, input bit fixed, input logic [511:0] wd);
        bit hit, conf;
        int t_prem, t_act, t_cmd, t_b0, t_last, t_rv, t_pre, t_end, t_ready, w, kind;
        logic [511:0] data;
        logic [15:0]  sync_mid, sync_end;
        logic [16:0]  ea;
        logic [1:0]   ecs;
        bit [32:0]    key;
        bit           eoe;

        key  = {which, rank, 4'(bank), row, col};
        hit  = which && m_vld[which][rank][bank] && (m_row[which][rank][bank] == row);
        conf = m_vld[which][rank][bank] && !hit;
        t_prem = -1; t_act = -1; t_pre = -1; t_rv = -1;
        if (hit) t_cmd = 0;
        else begin
            if (conf) begin t_prem = 0; t_act = TRP + 1; end
            else t_act = 0;
            t_cmd = t_act + TRCD;
        end
        t_b0   = t_cmd + (wr ? TCWL : TCL) + 1;
        t_last = t_b0 + BL - 1;
        t_end  = wr ? t_last + TWR + 1 : t_last + 1;
        if (!wr) t_rv = t_last + 1;
        if (!which) begin t_pre = t_end; t_ready = t_end + TRP + 1; end
        else t_ready = t_end;

        if (wr) data = fixed ? wd : rand_burst();
        else if (mem.exists(key)) data = mem[key];
        else data = rand_burst();
        mem[key] = data;

        sync_mid = model_sync(which) | (16'h1 << bank);
        m_vld[which][rank][bank] = which;
        m_row[which][rank][bank] = row;
        sync_end = model_sync(which);

        sel = which;
        #1;
        w = 0;
        while (o_rdy !== 1'b1 && w < 400) begin @(negedge ck_t); w++; end
        checks++;
        if (o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout inst=%0d: ready=%b required 1", which, o_rdy);
            return;
        end
        req_write = wr; req_rank = rank; req_bg = 2'(bank >> 2); req_ba = 2'(bank);
        req_row = row; req_col = col; req_wdata = wr ? data : rand_burst();
        if (which) v_op = 1'b1; else v_cp = 1'b1;
        @(posedge ck_t);
        #1;
        if (!hold) begin v_cp = 1'b0; v_op = 1'b0; end

        for (int n = 0; n <= t_ready; n++) begin
            @(negedge ck_t);
            if (!wr && n >= t_b0 && n <= t_last) dq_in = data[(n-t_b0)*64 +: 64];
            else dq_in = {$urandom, $urandom};

            kind = 0;
            if (n == t_prem || n == t_pre) kind = 3;
            else if (n == t_act) kind = 1;
            else if (n == t_cmd) kind = 2;
            case (kind)
                1: ea = row;
                2: ea = {(wr ? 3'b100 : 3'b101), 4'b0, col};
                3: ea = {3'b010, 4'b0, col};
                default: ea = '0;
            endcase
            ecs = (kind != 0) ? ~(2'b01 << rank) : 2'b11;

            checks++;
            if (o_cs !== ecs) begin
                errors++;
                $display("FAIL cs_n inst=%0d c%0d: got %b required %b", which, n, o_cs, ecs);
            end
            checks++;
            if ({o_act, o_a} !== {(kind != 1), ea}) begin
                errors++;
                $display("FAIL cmd_bus inst=%0d c%0d: act_n/A got %b/%h required %b/%h",
                         which, n, o_act, o_a, (kind != 1), ea);
            end
            if (kind != 0) begin
                checks++;
                if ({o_bg, o_ba} !== 4'(bank)) begin
                    errors++;
                    $display("FAIL bank inst=%0d c%0d: got %0d required %0d",
                             which, n, {o_bg, o_ba}, bank);
                end
            end
            eoe = wr && n >= t_b0 && n <= t_last;
            checks++;
            if (o_oe !== eoe || o_dqst !== (eoe ? 16'hFFFF : 16'h0) ||
                o_dqsc !== (eoe ? 16'h0 : 16'hFFFF)) begin
                errors++;
                $display("FAIL dq_oe_dqs inst=%0d c%0d: oe/t/c got %b/%h/%h required %b",
                         which, n, o_oe, o_dqst, o_dqsc, eoe);
            end
            if (eoe) begin
                checks++;
                if (o_dq !== data[(n-t_b0)*64 +: 64]) begin
                    errors++;
                    $display("FAIL dq_out inst=%0d c%0d: got %h required %h",
                             which, n, o_dq, data[(n-t_b0)*64 +: 64]);
                end
            end
            checks++;
            if (o_rv !== (n == t_rv)) begin
                errors++;
                $display("FAIL rdata_valid inst=%0d c%0d: got %b required %b",
                         which, n, o_rv, (n == t_rv));
            end
            checks++;
            if (o_rdy !== (n == t_ready)) begin
                errors++;
                $display("FAIL req_ready inst=%0d c%0d: got %b required %b",
                         which, n, o_rdy, (n == t_ready));
            end
            if (n == t_cmd) begin
                checks++;
                if (o_sync !== sync_mid) begin
                    errors++;
                    $display("FAIL sync_at_cmd inst=%0d: got %h required %h",
                             which, o_sync, sync_mid);
                end
            end
            if (n == abort_at) begin
                reset_n = 1'b0;
                mem.delete(key);
                return;
            end
            if (n == t_ready) begin
                checks++;
                if (o_sync !== sync_end) begin
                    errors++;
                    $display("FAIL sync_end inst=%0d: got %h required %h",
                             which, o_sync, sync_end);
                end
                if (!wr) begin
                    checks++;
                    if (o_rdata !== data) begin
                        errors++;
                        $display("FAIL rdata inst=%0d: got %h required %h",
                                 which, o_rdata[63:0], data[63:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge ck_t);
        checks++;
        if ({rdy_cp, rdy_op, cs_cp, cs_op, act_cp, act_op, a_cp, a_op} !== {2'b00, 3'b111, 2'b11, 34'h0}) begin
            errors++;
            $display("FAIL reset_cmd: ready=%b%b cs=%b/%b act=%b%b A=%h/%h required idle bus",
                     rdy_cp, rdy_op, cs_cp, cs_op, act_cp, act_op, a_cp, a_op);
        end
        checks++;
        if ({bg_cp, ba_cp, bg_op, ba_op, oe_cp, oe_op, dq_cp, dq_op} !== '0) begin
            errors++;
            $display("FAIL reset_bank_dq: bg/ba/oe/dq not all zero (oe=%b%b)", oe_cp, oe_op);
        end
        checks++;
        if ({dqst_cp, dqst_op, dqsc_cp, dqsc_op} !== {32'h0, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL reset_dqs: t=%h/%h c=%h/%h required 0/0 ffff/ffff",
                     dqst_cp, dqst_op, dqsc_cp, dqsc_op);
        end
        checks++;
        if ({rdata_cp, rdata_op, rv_cp, rv_op, sync_cp, sync_op} !== '0) begin
            errors++;
            $display("FAIL reset_rdata_sync: rv=%b%b sync=%h/%h required 0", rv_cp, rv_op,
                     sync_cp, sync_op);
        end
        reset_n = 1'b1;
        @(negedge ck_t);
        checks++;
        if ({rdy_cp, rdy_op} !== 2'b11) begin
            errors++;
            $display("FAIL ready_after_reset: got %b%b required 11", rdy_cp, rdy_op);
        end
    endtask

    task automatic test_closed_write_read();
        logic [511:0] wd;
        for (int k = 0; k < 8; k++) wd[k*64 +: 64] = 64'hA0 + 64'(k);
        do_req(0, 1, 0, 5, 17'd1, 10'd2, 0, -1, 1, wd);
        do_req(0, 0, 0, 5, 17'd1, 10'd2, 0, -1, 0, '0);
    endtask

    task automatic test_open_hit_and_conflict();
        do_req(1, 1, 0, 5, 17'd1, 10'd2, 0, -1, 0, '0);
        do_req(1, 0, 0, 5, 17'd1, 10'd2, 0, -1, 0, '0);  // hit: RD at c0
        do_req(1, 0, 0, 5, 17'd4, 10'd7, 0, -1, 0, '0);  // conflict: PRE/ACT/RD
        do_req(1, 0, 0, 5, 17'd4, 10'd7, 0, -1, 0, '0);  // row 4 now a hit
    endtask

    task automatic test_reset_mid_burst();
        // Row 4 is open on the open-page instance, so the write is a hit and
        // beat 3 falls on c(TCWL+1+3).
        do_req(1, 1, 0, 5, 17'd4, 10'd9, 0, TCWL + 4, 0, '0);
        #1;
        checks++;
        if ({oe_op, cs_op, sync_op, rdy_op} !== {1'b0, 2'b11, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_burst: oe=%b cs=%b sync=%h ready=%b required 0/11/0/0",
                     oe_op, cs_op, sync_op, rdy_op);
        end
        clear_model();
        @(negedge ck_t);
        reset_n = 1'b1;
        @(negedge ck_t);
        do_req(1, 0, 0, 5, 17'd4, 10'd9, 0, -1, 0, '0);  // table cleared: ACT first
    endtask

    task automatic test_back_to_back_rank1();
        do_req(1, 1, 1, 2, 17'd33, 10'd5, 1, -1, 0, '0);  // valid held while busy
        do_req(1, 0, 1, 2, 17'd33, 10'd5, 0, -1, 0, '0);
    endtask

    task automatic test_random();
        int banks [3] = '{0, 5, 15};
        int rows [3] = '{1, 4, 9};
        bit which;
        for (int i = 0; i < 24; i++) begin
            which = 1'($urandom_range(0, 1));
            do_req(which, 1'($urandom_range(0, 1)), which ? 1'($urandom_range(0, 1)) : 1'b0,
                   banks[$urandom_range(0, 2)], 17'(rows[$urandom_range(0, 2)]),
                   10'($urandom_range(0, 3)), 0, -1, 0, '0);
        end
    endtask

    initial begin
        v_cp = 0; v_op = 0; sel = 0; req_write = 0; req_rank = 0; req_bg = 0; req_ba = 0;
        req_row = 0; req_col = 0; req_wdata = '0; dq_in = '0;
        clear_model();
        test_reset();
        test_closed_write_read();
        test_open_hit_and_conflict();
        test_reset_mid_burst();
        test_back_to_back_rank1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
